comparator_serial_accumulator: RTL and testbench

Consumes per-bit LT/EQ/GT flags from a 1-bit comparator, presented MSB-first one bit per beat. Folds them into a DATA_WIDTH-bit magnitude comparison result. The first non-equal bit decides the result; if every bit is equal, the result is EQ. Sits directly downstream of the 1-bit comparator in bit-serial compare paths, with valid/ready handshakes on both sides.

---
 rtl/comparator_pkg.sv | 22 ++
 rtl/comparator_bit_counter.sv | 47 ++++
 rtl/comparator_serial_accumulator.sv | 192 +++++++++++++++++++
 tb/tb_comparator_serial_accumulator.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the bit-serial comparator accumulator.
// Contents: FSM state encoding, latched-decision encoding, count-width helper.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        UNDECIDED = 2'd0,
        DEC_LT    = 2'd1,
        DEC_GT    = 2'd2
    } decision_t;

    // Bits needed to hold a beat count of 0..dw inclusive.
    function automatic int unsigned count_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/comparator_bit_counter.sv
// Beat counter for the serial comparator: synchronous clear, count enable,
// and a lookahead flag telling that the next enabled increment lands on DATA_WIDTH.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   clear_i         zero the count (wins over enable)
//   enable_i        count one accepted beat
//   count_o         beats counted so far (registered)
//   last_beat_c     count_o == DATA_WIDTH-1 (combinational)
module comparator_bit_counter
    import comparator_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned CNT_W      = count_width(DATA_WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_beat_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign last_beat_c = (count_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/comparator_serial_accumulator.sv
// Folds MSB-first per-bit LT/EQ/GT flags into a word-level magnitude compare.
// The first non-equal beat decides; all-equal gives EQ.
// Optional build macro: ONEHOT_CHECK_EN (flags non-one-hot beats via sticky Error_Out).
// Ports:
//   Clock_In, Reset_In                clock, async active-low reset
//   Start_In                          begin a comparison (honoured in IDLE only)
//   Bit_Valid_In / Bit_Ready_Out      per-beat handshake
//   A_*_In                            per-bit flags from the 1-bit comparator
//   Result_Valid_Out / Result_Ready_In result handshake
//   A_*_Out                           one-hot word result, valid with Result_Valid_Out
//   Bit_Count_Out                     beats accepted in the current comparison
//   Error_Out                         sticky illegal-flag indicator
module comparator_serial_accumulator
    import comparator_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned CNT_W      = count_width(DATA_WIDTH)
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Start_In,
    input  logic             Bit_Valid_In,
    output logic             Bit_Ready_Out,
    input  logic             A_Less_Than_B_In,
    input  logic             A_Equal_To_B_In,
    input  logic             A_Greater_Than_B_In,
    output logic             Result_Valid_Out,
    input  logic             Result_Ready_In,
    output logic             A_Less_Than_B_Out,
    output logic             A_Equal_To_B_Out,
    output logic             A_Greater_Than_B_Out,
    output logic [CNT_W-1:0] Bit_Count_Out,
    output logic             Error_Out
);

    state_t    state_q, state_d;
    decision_t decision_q, decision_d, decision_upd;
    logic      bit_ready_q, bit_ready_d;
    logic      result_valid_q, result_valid_d;
    logic      lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic      cnt_clear, cnt_enable, last_beat;
    logic      beat_xfer, beat_lt, beat_gt;

    assign beat_xfer = Bit_Valid_In & bit_ready_q;

    // Beat decode: illegal flag combinations count as equal when checking is on.
`ifdef ONEHOT_CHECK_EN
    logic flags_onehot;
    logic err_q, err_d;

    assign flags_onehot = (A_Less_Than_B_In ^ A_Equal_To_B_In ^ A_Greater_Than_B_In)
                        & ~(A_Less_Than_B_In & A_Equal_To_B_In & A_Greater_Than_B_In);
    assign beat_lt      = flags_onehot & A_Less_Than_B_In;
    assign beat_gt      = flags_onehot & A_Greater_Than_B_In;

    // Sticky error: cleared only by an accepted start.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && Start_In) begin
            err_d = 1'b0;
        end else if (beat_xfer && !flags_onehot) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Error_Out = err_q;
`else
    logic unused_eq_flag;

    // LT wins over GT; EQ flag is implied by neither being set.
    assign beat_lt        = A_Less_Than_B_In;
    assign beat_gt        = ~A_Less_Than_B_In & A_Greater_Than_B_In;
    assign unused_eq_flag = A_Equal_To_B_In;
    assign Error_Out      = 1'b0;
`endif

    // Decision after this beat: only an undecided comparison can latch.
    always_comb begin
        decision_upd = decision_q;
        if (decision_q == UNDECIDED) begin
            if (beat_lt) begin
                decision_upd = DEC_LT;
            end else if (beat_gt) begin
                decision_upd = DEC_GT;
            end
        end
    end

    comparator_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .clk_i       (Clock_In),
        .rst_ni      (Reset_In),
        .clear_i     (cnt_clear),
        .enable_i    (cnt_enable),
        .count_o     (Bit_Count_Out),
        .last_beat_c (last_beat)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        decision_d     = decision_q;
        bit_ready_d    = bit_ready_q;
        result_valid_d = result_valid_q;
        lt_d           = lt_q;
        eq_d           = eq_q;
        gt_d           = gt_q;
        cnt_clear      = 1'b0;
        cnt_enable     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start_In) begin
                    state_d     = ACCUM;
                    decision_d  = UNDECIDED;
                    bit_ready_d = 1'b1;
                    cnt_clear   = 1'b1;
                end
            end
            ACCUM: begin
                if (beat_xfer) begin
                    cnt_enable = 1'b1;
                    decision_d = decision_upd;
                    if (last_beat) begin
                        state_d        = DONE;
                        bit_ready_d    = 1'b0;
                        result_valid_d = 1'b1;
                        lt_d           = (decision_upd == DEC_LT);
                        gt_d           = (decision_upd == DEC_GT);
                        eq_d           = (decision_upd == UNDECIDED);
                    end
                end
            end
            DONE: begin
                if (result_valid_q && Result_Ready_In) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                    lt_d           = 1'b0;
                    eq_d           = 1'b0;
                    gt_d           = 1'b0;
                    cnt_clear      = 1'b1;
                end
            end
            default: begin
                state_d        = IDLE;
                decision_d     = UNDECIDED;
                bit_ready_d    = 1'b0;
                result_valid_d = 1'b0;
                lt_d           = 1'b0;
                eq_d           = 1'b0;
                gt_d           = 1'b0;
                cnt_clear      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q        <= IDLE;
            decision_q     <= UNDECIDED;
            bit_ready_q    <= 1'b0;
            result_valid_q <= 1'b0;
            lt_q           <= 1'b0;
            eq_q           <= 1'b0;
            gt_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            decision_q     <= decision_d;
            bit_ready_q    <= bit_ready_d;
            result_valid_q <= result_valid_d;
            lt_q           <= lt_d;
            eq_q           <= eq_d;
            gt_q           <= gt_d;
        end
    end

    assign Bit_Ready_Out        = bit_ready_q;
    assign Result_Valid_Out     = result_valid_q;
    assign A_Less_Than_B_Out    = lt_q;
    assign A_Equal_To_B_Out     = eq_q;
    assign A_Greater_Than_B_Out = gt_q;

endmodule

// File: tb/tb_comparator_serial_accumulator.sv
// Self-checking bench: transaction-level reference model plus directed and random comparisons.
module tb_comparator_serial_accumulator;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          bvalid = 1'b0;
    logic          lt_i   = 1'b0;
    logic          eq_i   = 1'b0;
    logic          gt_i   = 1'b0;
    logic          rready = 1'b0;
    logic          bready, rvalid, lt_o, eq_o, gt_o, err_o;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comparator_serial_accumulator #(
        .DATA_WIDTH (W)
    ) dut (
        .Clock_In             (clk),
        .Reset_In             (rst_n),
        .Start_In             (start),
        .Bit_Valid_In         (bvalid),
        .Bit_Ready_Out        (bready),
        .A_Less_Than_B_In     (lt_i),
        .A_Equal_To_B_In      (eq_i),
        .A_Greater_Than_B_In  (gt_i),
        .Result_Valid_Out     (rvalid),
        .Result_Ready_In      (rready),
        .A_Less_Than_B_Out    (lt_o),
        .A_Equal_To_B_Out     (eq_o),
        .A_Greater_Than_B_Out (gt_o),
        .Bit_Count_Out        (cnt),
        .Error_Out            (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 waiting for start, 1 collecting beats, 2 holding a result.
    int         phase = 0;
    int         beats = 0;
    logic [2:0] beatq[$];   // {lt,eq,gt} of every accepted beat, in order

    function automatic bit beat_legal(input logic [2:0] f);
`ifdef ONEHOT_CHECK_EN
        return $countones(f) == 1;
`else
        return 1'b1;
`endif
    endfunction

    // Word result from the beat history: 0 = EQ, 1 = LT, 2 = GT.
    function automatic int verdict();
        foreach (beatq[i]) begin
            if (beat_legal(beatq[i])) begin
                if (beatq[i][2]) return 1;
                if (beatq[i][0]) return 2;
            end
        end
        return 0;
    endfunction

    function automatic bit any_illegal();
        foreach (beatq[i]) begin
            if (!beat_legal(beatq[i])) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            beats = 0;
            beatq.delete();
        end else begin
            case (phase)
                0: if (start) begin
                    phase = 1;
                    beats = 0;
                    beatq.delete();
                end
                1: if (bvalid) begin
                    beatq.push_back({lt_i, eq_i, gt_i});
                    beats++;
                    if (beats == int'(W)) phase = 2;
                end
                default: if (rready) begin
                    phase = 0;
                    beats = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        int v;
        v = verdict();
        chk("bit_ready", 32'(bready), 32'(phase == 1));
        chk("result_valid", 32'(rvalid), 32'(phase == 2));
        chk("lt_out", 32'(lt_o), 32'(phase == 2 && v == 1));
        chk("eq_out", 32'(eq_o), 32'(phase == 2 && v == 0));
        chk("gt_out", 32'(gt_o), 32'(phase == 2 && v == 2));
        chk("bit_count", 32'(cnt), 32'(beats));
        chk("error_out", 32'(err_o), 32'(any_illegal()));
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmp();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic l, input logic e, input logic g, input int gap, input bit noise);
        bvalid = 1'b1;
        lt_i   = l;
        eq_i   = e;
        gt_i   = g;
        start  = noise && ($urandom_range(0, 3) == 0);
        step();
        bvalid = 1'b0;
        start  = 1'b0;
        repeat (gap) begin
            lt_i = 1'($urandom);
            gt_i = 1'($urandom);
            step();
        end
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
        for (int i = int'(W) - 1; i >= 0; i--) begin
            send_beat(~a[i] & b[i], a[i] == b[i], a[i] & ~b[i], (i == 0) ? 0 : gap, 1'b0);
        end
    endtask

    // Waits (bounded) for a result; returns negedges waited, or -1 on timeout.
    task automatic wait_result(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rvalid) begin
                n = k;
                break;
            end
        end
        if (n < 0) begin
            errors++;
            checks++;
            $display("FAIL result_timeout: no Result_Valid_Out within 40 cycles at %0t", $time);
        end
    endtask

    task automatic take_result(input int hold, input bit poke_start);
        @(posedge clk);
        #1;
        rready = 1'b0;
        repeat (hold) begin
            start = poke_start;
            step();
            start = 1'b0;
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic chk_result(input string name, input logic [2:0] exp_lge, input logic exp_err);
        chk({name, "_lt_eq_gt"}, 32'({lt_o, eq_o, gt_o}), 32'(exp_lge));
        chk({name, "_count"}, 32'(cnt), 32'(W));
        chk({name, "_err"}, 32'(err_o), 32'(exp_err));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        logic [W-1:0] a, b;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({bready, rvalid, lt_o, eq_o, gt_o, err_o}), 32'(0));
        chk("reset_count", 32'(cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Equal words, back-to-back beats; result one cycle after the last beat.
        start_cmp();
        send_word(8'hA5, 8'hA5, 0);
        wait_result(n);
        chk("eq_latency", 32'(n), 32'(1));
        chk_result("eq_a5", 3'b010, 1'b0);
        take_result(0, 1'b0);

        // GT decided on the first beat, remaining beats still consumed.
        start_cmp();
        send_word(8'h80, 8'h7F, 0);
        wait_result(n);
        chk_result("gt_80_7f", 3'b001, 1'b0);
        take_result(0, 1'b0);

        // LT decided on the final beat with 2-cycle gaps between beats.
        start_cmp();
        send_word(8'h12, 8'h13, 2);
        wait_result(n);
        chk_result("lt_12_13", 3'b100, 1'b0);

        // Result held 3 cycles with Start pulsed in DONE.
        take_result(3, 1'b1);
        @(negedge clk);
        chk("after_take_valid", 32'(rvalid), 32'(0));
        chk("after_take_count", 32'(cnt), 32'(0));
        step();

        // Reset after beat 4 aborts; then a clean equal compare.
        start_cmp();
        for (int i = 0; i < 4; i++) send_beat(1'b0, 1'b0, 1'b1, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'({bready, rvalid, lt_o, eq_o, gt_o}), 32'(0));
        chk("abort_count", 32'(cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        start_cmp();
        send_word(8'h3C, 8'h3C, 0);
        wait_result(n);
        chk_result("eq_after_abort", 3'b010, 1'b0);
        take_result(0, 1'b0);

        // Beat 3 carries LT and GT together.
        start_cmp();
        for (int i = 1; i <= int'(W); i++) begin
            if (i == 3) send_beat(1'b1, 1'b0, 1'b1, 0, 1'b0);
            else        send_beat(1'b0, 1'b1, 1'b0, 0, 1'b0);
        end
        wait_result(n);
`ifdef ONEHOT_CHECK_EN
        chk_result("illegal_beat", 3'b010, 1'b1);
`else
        chk_result("illegal_beat", 3'b100, 1'b0);
`endif
        take_result(1, 1'b0);
        start_cmp();
        @(negedge clk);
        chk("err_cleared_by_start", 32'(err_o), 32'(0));
        @(posedge clk);
        #1;
        send_word(8'h00, 8'hFF, 0);
        wait_result(n);
        chk_result("lt_00_ff", 3'b100, 1'b0);
        take_result(0, 1'b0);

        // Random comparisons with idle noise, gaps, stray starts, illegal flags and ready stalls.
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                bvalid = 1'($urandom);
                lt_i   = 1'($urandom);
                gt_i   = 1'($urandom);
                step();
            end
            bvalid = 1'b0;
            start_cmp();
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            for (int i = int'(W) - 1; i >= 0; i--) begin
                if ($urandom_range(0, 11) == 0)
                    send_beat(1'($urandom), 1'($urandom), 1'($urandom),
                              (i == 0) ? 0 : $urandom_range(0, 2), 1'b1);
                else
                    send_beat(~a[i] & b[i], a[i] == b[i], a[i] & ~b[i],
                              (i == 0) ? 0 : $urandom_range(0, 2), 1'b1);
            end
            wait_result(n);
            take_result($urandom_range(0, 3), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
